spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 156 +++++++++++++++
 tb/tb_spi_master.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master: sends one command/address/data frame on MOSI and, for read-data
// commands, turns the bus around and captures a byte from MISO.
module spi_master #(
    parameter int unsigned FRAME_BITS = 10,
    parameter int unsigned RD_BITS    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] cmd_data,
    output logic                  busy,
    output logic                  done,
    output logic [RD_BITS-1:0]    rd_data,
    output logic                  rd_valid,
    output logic                  SS_n,
    output logic                  MOSI,
    input  logic                  MISO
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TURN_CY = 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_TURN  = 3'd4;
    localparam logic [2:0] S_RECV  = 3'd5;
    localparam logic [2:0] S_STOP  = 3'd6;

    logic [2:0]            r_state,   w_state_nx;
    logic [CNT_W-1:0]      r_cnt,     w_cnt_nx;
    logic [FRAME_BITS-1:0] r_shift,   w_shift_nx;
    logic [RD_BITS-1:0]    r_rx,      w_rx_nx;
    logic [RD_BITS-1:0]    r_rd_data, w_rd_data_nx;
    logic                  r_is_rd,   w_is_rd_nx;
    logic                  r_ss_n,    w_ss_n_nx;
    logic                  r_mosi,    w_mosi_nx;
    logic                  r_busy,    w_busy_nx;
    logic                  r_done,    w_done_nx;
    logic                  r_rd_valid, w_rd_valid_nx;

    // State register; outputs are flopped from the next-state decode so they
    // line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_rx       <= '0;
            r_rd_data  <= '0;
            r_is_rd    <= 1'b0;
            r_ss_n     <= 1'b1;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_shift    <= w_shift_nx;
            r_rx       <= w_rx_nx;
            r_rd_data  <= w_rd_data_nx;
            r_is_rd    <= w_is_rd_nx;
            r_ss_n     <= w_ss_n_nx;
            r_mosi     <= w_mosi_nx;
            r_busy     <= w_busy_nx;
            r_done     <= w_done_nx;
            r_rd_valid <= w_rd_valid_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_shift_nx    = r_shift;
        w_rx_nx       = r_rx;
        w_rd_data_nx  = r_rd_data;
        w_is_rd_nx    = r_is_rd;
        w_ss_n_nx     = 1'b1;
        w_mosi_nx     = 1'b0;
        w_busy_nx     = 1'b0;
        w_done_nx     = 1'b0;
        w_rd_valid_nx = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_SETUP;
                    w_shift_nx = cmd_data;
                    w_is_rd_nx = (cmd_data[FRAME_BITS-1 -: 2] == 2'b11);
                end
            end
            S_SETUP: begin
                w_state_nx = S_SHIFT;
                w_cnt_nx   = CNT_W'(FRAME_BITS);
            end
            S_SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nx = r_is_rd ? S_TURN : S_HOLD;
                    w_cnt_nx   = r_is_rd ? CNT_W'(TURN_CY) : '0;
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            S_HOLD: begin
                w_state_nx = S_STOP;
            end
            S_TURN: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nx = S_RECV;
                    w_cnt_nx   = CNT_W'(RD_BITS);
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            S_RECV: begin
                // MISO is only ever looked at here, so it may float elsewhere
                w_rx_nx = {r_rx[RD_BITS-2:0], MISO};
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nx   = S_STOP;
                    w_cnt_nx     = '0;
                    w_rd_data_nx = {r_rx[RD_BITS-2:0], MISO};
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            S_STOP: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // Output decode of the state being entered
        w_ss_n_nx     = (w_state_nx == S_IDLE) || (w_state_nx == S_STOP);
        w_busy_nx     = (w_state_nx != S_IDLE);
        w_done_nx     = (w_state_nx == S_STOP);
        w_rd_valid_nx = (w_state_nx == S_STOP) && r_is_rd;
        if (w_state_nx == S_SETUP) begin
            w_mosi_nx = w_shift_nx[FRAME_BITS-1];
        end else if (w_state_nx == S_SHIFT) begin
            w_mosi_nx  = r_shift[FRAME_BITS-1];
            w_shift_nx = {r_shift[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign SS_n     = r_ss_n;
    assign MOSI     = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master against a frame-level slave/register model.
module tb_spi_master;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] cmd_data;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    int unsigned n_vec;
    int unsigned n_bad;

    logic [7:0] mem [256];
    logic [7:0] addr;
    logic [7:0] exp_rd;

    spi_master #(.FRAME_BITS(10), .RD_BITS(8)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cmd_data (cmd_data),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected MOSI bits over the SS_n-low window: direction bit, full frame MSB first, then zeros
    function automatic int unsigned exp_mosi(input logic [9:0] cmd, input int nlow);
        int unsigned e;
        e = 32'(cmd[9]);
        for (int i = 9; i >= 0; i--) e = (e << 1) | 32'(cmd[i]);
        for (int k = 11; k < nlow; k++) e = e << 1;
        return e;
    endfunction

    task automatic run_frame(input logic [9:0] cmd, input bit ones_after);
        int          lowcnt;
        int          dcnt;
        int          rcnt;
        int          after;
        int          nlow;
        bit          seen;
        bit          is_rd;
        int unsigned mosi_got;
        logic [7:0]  miso_byte;
        logic [7:0]  rd_at_done;

        is_rd      = (cmd[9:8] == 2'b11);
        nlow       = is_rd ? 21 : 12;
        miso_byte  = mem[addr];
        lowcnt     = 0;
        dcnt       = 0;
        rcnt       = 0;
        after      = 0;
        seen       = 1'b0;
        mosi_got   = 0;
        rd_at_done = 8'h00;

        @(negedge clk);
        cmd_data = cmd;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cmd_data = ones_after ? 10'h3FF : 10'($urandom);

        for (int c = 0; c < 40 && after < 2; c++) begin
            if (!SS_n) begin
                lowcnt++;
                mosi_got = (mosi_got << 1) | 32'(MOSI);
            end
            if (done) begin
                dcnt++;
                rd_at_done = rd_data;
                seen = 1'b1;
            end
            if (rd_valid) rcnt++;
            if (seen) after++;
            // The slave returns its byte MSB first on SS_n-low cycles 14..21 of a read-data frame
            if (is_rd && lowcnt >= 14 && lowcnt <= 21) MISO = miso_byte[7 - (lowcnt - 14)];
            else MISO = 1'($urandom);
            @(negedge clk);
        end

        case (cmd[9:8])
            2'b00:   addr = cmd[7:0];
            2'b01:   mem[addr] = cmd[7:0];
            2'b10:   addr = cmd[7:0];
            default: exp_rd = miso_byte;
        endcase

        check("ss_low_width", 32'(lowcnt), 32'(nlow));
        check("mosi_seq", mosi_got, exp_mosi(cmd, nlow));
        check("done_pulses", 32'(dcnt), 32'd1);
        check("rd_valid_pulses", 32'(rcnt), 32'(is_rd));
        check("rd_data", 32'(rd_at_done), 32'(exp_rd));
    endtask

    initial begin
        int d1;
        int f2;
        int falls_pre;
        int c2;
        int dcnt;
        int rcnt;
        int lows;
        logic prev_ss;
        logic [9:0] rcmd;

        n_vec    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        cmd_data = '0;
        MISO     = 1'b0;
        addr     = 8'h00;
        exp_rd   = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        check("rst_ss_n", 32'(SS_n), 32'd1);
        check("rst_mosi", 32'(MOSI), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;

        // Directed write-address and read-data frames
        run_frame(10'b00_1010_0101, 1'b0);
        mem[addr] = 8'hC3;
        run_frame(10'b11_0000_0000, 1'b0);

        // Loopback through the slave register model
        run_frame(10'h010, 1'b0);
        run_frame(10'h15A, 1'b0);
        run_frame(10'h210, 1'b0);
        run_frame(10'h300, 1'b0);
        check("loopback_rd_data", 32'(rd_data), 32'h5A);

        // Frame contents must survive cmd_data changing after acceptance
        run_frame(10'h100, 1'b1);

        // Random frames
        for (int n = 0; n < 40; n++) begin
            rcmd = 10'($urandom);
            run_frame(rcmd, n[0]);
        end

        // start held high: one frame, then a new one no sooner than 2 cycles after done
        @(negedge clk);
        cmd_data  = 10'h0A5;
        start     = 1'b1;
        d1        = -1;
        f2        = -1;
        falls_pre = 0;
        prev_ss   = SS_n;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done && d1 < 0) d1 = c;
            if (prev_ss && !SS_n) begin
                if (d1 < 0) falls_pre++;
                else if (f2 < 0) f2 = c;
            end
            prev_ss = SS_n;
        end
        start = 1'b0;
        check("held_one_frame", 32'(falls_pre), 32'd1);
        check("held_second_seen", 32'(f2 > 0), 32'd1);
        check("held_gap_ge2", 32'((f2 - d1) >= 2), 32'd1);
        c2 = 0;
        while (busy && c2 < 40) begin
            @(negedge clk);
            c2++;
        end
        check("held_drain", 32'(busy), 32'd0);
        addr = 8'hA5;

        // Reset in SHIFT cycle 5 of a read-data frame
        @(negedge clk);
        cmd_data = 10'h300;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_ss_low", 32'(SS_n), 32'd0);
        rst = 1'b1;
        #1;
        check("abort_ss_n", 32'(SS_n), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mosi", 32'(MOSI), 32'd0);
        check("abort_rd_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        exp_rd = 8'h00;
        dcnt   = 0;
        rcnt   = 0;
        lows   = 0;
        for (int c = 0; c < 30; c++) begin
            MISO = 1'($urandom);
            @(negedge clk);
            if (done) dcnt++;
            if (rd_valid) rcnt++;
            if (!SS_n) lows++;
        end
        check("abort_no_done", 32'(dcnt), 32'd0);
        check("abort_no_rd_valid", 32'(rcnt), 32'd0);
        check("abort_ss_stays_high", 32'(lows), 32'd0);
        check("abort_rd_data_kept", 32'(rd_data), 32'd0);

        // First start after reset is accepted normally
        run_frame(10'h2A5, 1'b0);
        mem[addr] = 8'h96;
        run_frame(10'h3FF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
